// File: rtl/roi_sum_driver_if.sv
// ============================================================================
// Module      : roi_sum_driver_if
// Description : Bus bundle between the ROI sum driver and its controller/ROI.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface roi_sum_driver_if #(
  parameter int DIN_N = 8
) ();
  logic             start;
  logic [DIN_N-1:0] sumin;
  logic [DIN_N-1:0] sumout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_cnt;

  // master: controller plus ROI side; slave: the driver block itself
  modport master (
    output start, sumout,
    input  sumin, busy, done, pass, err_cnt
  );

  modport slave (
    input  start, sumout,
    output sumin, busy, done, pass, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/roi_sum_driver.sv
// ============================================================================
// Module      : roi_sum_driver
// Description : Drives the ROI sumin bus with a deterministic pattern and checks
//               sumout against a bit-exact accumulator model.
//               Optional macro ROI_SUM_DRIVER_LFSR_EN selects the LFSR pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module roi_sum_driver #(
  parameter int DIN_N      = 8,
  parameter int N_CHECKS   = 16,
  parameter int SETTLE_CYC = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  roi_sum_driver_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] c_settle_last = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] c_run_last    = 16'(N_CHECKS - 1);
  localparam logic [15:0] c_drain_last  = 16'd1;
  localparam logic [15:0] c_err_max     = 16'hFFFF;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic [DIN_N-1:0] r_sumin, w_sumin_nxt;
  logic [DIN_N-1:0] r_e, w_e_nxt;
  logic [DIN_N-1:0] r_e_d, w_e_d_nxt;
  logic [15:0]      r_err, w_err_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic             w_pat_clr;
  logic             w_pat_adv;
  logic [DIN_N-1:0] w_pat_word;
  logic             w_cmp;

`ifdef ROI_SUM_DRIVER_LFSR_EN
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  localparam logic [15:0] c_lfsr_taps = 16'hB400;

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_step;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 16'h0000);

  if (DIN_N > 16) begin : g_pat_wide
    assign w_pat_word = {{(DIN_N-16){1'b0}}, w_lfsr_step};
  end else begin : g_pat_narrow
    assign w_pat_word = w_lfsr_step[DIN_N-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || w_pat_clr) begin
      r_lfsr <= c_lfsr_seed;
    end else if (w_pat_adv) begin
      r_lfsr <= w_lfsr_step;
    end
  end
`else
  logic [DIN_N-1:0] r_pat;

  assign w_pat_word = r_pat + DIN_N'(1);

  always_ff @(posedge clk) begin
    if (rst || w_pat_clr) begin
      r_pat <= '0;
    end else if (w_pat_adv) begin
      r_pat <= w_pat_word;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sumin <= '0;
      r_e     <= '0;
      r_e_d   <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sumin <= w_sumin_nxt;
      r_e     <= w_e_nxt;
      r_e_d   <= w_e_d_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  assign w_cmp = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sumin_nxt = '0;
    w_e_nxt     = r_e;
    w_e_d_nxt   = r_e_d;
    w_err_nxt   = r_err;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_pat_clr   = 1'b0;
    w_pat_adv   = 1'b0;

    // sumout lags the ROI result by one register, hence compare against E_d
    if (w_cmp) begin
      w_e_nxt   = r_e + r_sumin;
      w_e_d_nxt = r_e;
      if ((bus.sumout != r_e_d) && (r_err != c_err_max)) begin
        w_err_nxt = r_err + 16'd1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
          w_err_nxt   = '0;
          w_pass_nxt  = 1'b0;
          w_pat_clr   = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_SETTLE: begin
        w_busy_nxt = 1'b1;
        if (r_cnt == c_settle_last) begin
          // ROI has no reset: its settled value becomes the model baseline
          w_e_nxt     = bus.sumout;
          w_e_d_nxt   = bus.sumout;
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
          w_sumin_nxt = w_pat_word;
          w_pat_adv   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_RUN: begin
        w_busy_nxt = 1'b1;
        if (r_cnt == c_run_last) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 16'd1;
          w_sumin_nxt = w_pat_word;
          w_pat_adv   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == c_drain_last) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_nxt == 16'd0);
        end else begin
          w_cnt_nxt  = r_cnt + 16'd1;
          w_busy_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.sumin   = r_sumin;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pass    = r_pass;
  assign bus.err_cnt = r_err;

endmodule

`default_nettype wire

// File: tb/tb_roi_sum_driver.sv
// ============================================================================
// Module      : tb_roi_sum_driver
// Description : Bench for roi_sum_driver with a behavioural ROI accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_roi_sum_driver;

  localparam int DIN_N      = 8;
  localparam int N_CHECKS   = 16;
  localparam int SETTLE_CYC = 4;
  localparam int RUN_LEN    = SETTLE_CYC + N_CHECKS + 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  roi_sum_driver_if #(.DIN_N(DIN_N)) bus ();

  roi_sum_driver #(
    .DIN_N      (DIN_N),
    .N_CHECKS   (N_CHECKS),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ROI: result accumulates sumin, sumout is result one register later
  logic       roi_load;
  logic [7:0] roi_load_val;
  logic [7:0] roi_result;
  logic [7:0] roi_q;
  always @(posedge clk) begin
    if (roi_load) begin
      roi_result <= roi_load_val;
      roi_q      <= roi_load_val;
    end else begin
      roi_result <= roi_result + bus.sumin;
      roi_q      <= roi_result;
    end
  end

  // bc = index of the current cycle within the busy window
  int bc;
  always @(posedge clk) begin
    if (rst || !bus.busy) bc <= 0;
    else                  bc <= bc + 1;
  end

  int         fault_mode;
  logic [7:0] sumout_drv;
  always_comb begin
    sumout_drv = roi_q;
    if (bus.busy && fault_mode == 1 && bc == SETTLE_CYC + 5)
      sumout_drv = roi_q ^ 8'h01;
    else if (bus.busy && fault_mode == 2 && bc >= SETTLE_CYC)
      sumout_drv = 8'h00;
  end
  assign bus.sumout = sumout_drv;

  logic [7:0]  exp_words[$];
  logic [15:0] exp_err[$];
  logic        exp_pass[$];
  logic [7:0]  exp_final[$];
  logic [7:0]  got_words[$];

  function automatic logic [7:0] exp_word(input int n);
    logic [15:0] l;
    l = 16'hACE1;
`ifdef ROI_SUM_DRIVER_LFSR_EN
    for (int i = 0; i <= n; i++) l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    return l[7:0];
`else
    l = 16'(n + 1);
    return l[7:0];
`endif
  endfunction

  task automatic push_expect(input logic [7:0] init, input logic [15:0] e, input logic p);
    logic [7:0] s;
    s = init;
    for (int n = 0; n < N_CHECKS; n++) begin
      exp_words.push_back(exp_word(n));
      s = s + exp_word(n);
    end
    exp_err.push_back(e);
    exp_pass.push_back(p);
    exp_final.push_back(s);
  endtask

  task automatic load_roi(input logic [7:0] v);
    @(negedge clk);
    roi_load = 1'b1; roi_load_val = v;
    @(negedge clk);
    roi_load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_run(input bit poke, output int t_start, output int t_busy, output int t_nz,
                        output int t_done, output logic [15:0] e, output logic p,
                        output logic pass0, output logic [15:0] err0, output logic busy_dn);
    t_busy = -1; t_nz = -1; t_done = -1; e = 'x; p = 1'bx;
    pass0 = 1'bx; err0 = 'x; busy_dn = 1'bx;
    got_words.delete();
    @(negedge clk);
    bus.start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy && t_busy < 0) begin
        t_busy = cyc; pass0 = bus.pass; err0 = bus.err_cnt;
      end
      if (bus.busy && bus.sumin != 8'h00 && t_nz < 0) t_nz = cyc;
      if (bus.busy && bc >= SETTLE_CYC && bc < SETTLE_CYC + N_CHECKS)
        got_words.push_back(bus.sumin);
      if (bus.done) begin
        t_done = cyc; e = bus.err_cnt; p = bus.pass; busy_dn = bus.busy;
        break;
      end
      bus.start = poke && bus.busy && (bc == 0 || bc == SETTLE_CYC + 2);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic [15:0] e, input logic p);
    logic [15:0] xe;
    logic        xp;
    logic [7:0]  xf;
    logic [7:0]  xw;
    logic [7:0]  gw;
    xe = exp_err.pop_front();
    xp = exp_pass.pop_front();
    xf = exp_final.pop_front();
    for (int n = 0; n < N_CHECKS; n++) begin
      xw = exp_words.pop_front();
      gw = (n < got_words.size()) ? got_words[n] : 8'hxx;
      n_cmp++;
      if (gw !== xw) begin
        n_bad++;
        $display("FAIL %s word%0d: got %h want %h", tag, n, gw, xw);
      end
    end
    n_cmp++;
    if (e !== xe) begin n_bad++; $display("FAIL %s err_cnt: got %0d want %0d", tag, e, xe); end
    n_cmp++;
    if (p !== xp) begin n_bad++; $display("FAIL %s pass: got %b want %b", tag, p, xp); end
    if (fault_mode == 0) begin
      n_cmp++;
      if (roi_q !== xf) begin n_bad++; $display("FAIL %s final sumout: got %h want %h", tag, roi_q, xf); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; roi_load = 1'b0; roi_load_val = 8'h00; fault_mode = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.sumin !== 8'h00) begin n_bad++; $display("FAIL reset sumin: got %h want 00", bus.sumin); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_cmp++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", bus.done); end
    n_cmp++;
    if (bus.pass !== 1'b0) begin n_bad++; $display("FAIL reset pass: got %b want 0", bus.pass); end
    n_cmp++;
    if (bus.err_cnt !== 16'h0) begin n_bad++; $display("FAIL reset err_cnt: got %0d want 0", bus.err_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_counter;
    int ts, tb_, tn, td;
    logic [15:0] e, e0;
    logic p, p0, bd;
    load_roi(8'h05);
    push_expect(8'h05, 16'd0, 1'b1);
    do_run(1'b0, ts, tb_, tn, td, e, p, p0, e0, bd);
    n_cmp++;
    if (tb_ - ts !== 1) begin n_bad++; $display("FAIL clean busy latency: got %0d want 1", tb_ - ts); end
    n_cmp++;
    if (tn - tb_ !== SETTLE_CYC) begin n_bad++; $display("FAIL clean first word offset: got %0d want %0d", tn - tb_, SETTLE_CYC); end
    n_cmp++;
    if (td - tb_ !== RUN_LEN) begin n_bad++; $display("FAIL clean done latency: got %0d want %0d", td - tb_, RUN_LEN); end
    n_cmp++;
    if (bd !== 1'b0) begin n_bad++; $display("FAIL clean busy at done: got %b want 0", bd); end
    check_results("clean", e, p);
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL clean done width: got %b want 0", bus.done); end
  endtask

  task automatic test_wrap;
    int ts, tb_, tn, td;
    logic [15:0] e, e0;
    logic p, p0, bd;
    load_roi(8'hF0);
    push_expect(8'hF0, 16'd0, 1'b1);
    do_run(1'b0, ts, tb_, tn, td, e, p, p0, e0, bd);
    n_cmp++;
    if (p0 !== 1'b0) begin n_bad++; $display("FAIL wrap pass cleared on start: got %b want 0", p0); end
    check_results("wrap", e, p);
  endtask

  task automatic test_fault(input int mode, input logic [7:0] init, input logic [15:0] xe);
    int ts, tb_, tn, td;
    logic [15:0] e, e0;
    logic p, p0, bd;
    load_roi(init);
    push_expect(init, xe, 1'b0);
    fault_mode = mode;
    do_run(1'b0, ts, tb_, tn, td, e, p, p0, e0, bd);
    check_results(mode == 1 ? "fault_bit" : "fault_zero", e, p);
    fault_mode = 0;
  endtask

  task automatic test_reset_mid_run;
    int ts, tb_, tn, td;
    logic [15:0] e, e0;
    logic p, p0, bd;
    logic [7:0] base;
    bit hit;
    load_roi(8'h33);
    fault_mode = 2;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy && bc == SETTLE_CYC + 7) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!hit || bus.err_cnt === 16'd0) begin n_bad++; $display("FAIL midrst pre-reset err_cnt: got %0d want nonzero", bus.err_cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fault_mode = 0;
    n_cmp++;
    if (bus.sumin !== 8'h00) begin n_bad++; $display("FAIL midrst sumin: got %h want 00", bus.sumin); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
    n_cmp++;
    if (bus.err_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst err_cnt: got %0d want 0", bus.err_cnt); end
    repeat (3) @(negedge clk);
    base = roi_result;
    push_expect(base, 16'd0, 1'b1);
    do_run(1'b0, ts, tb_, tn, td, e, p, p0, e0, bd);
    check_results("midrst_rerun", e, p);
  endtask

  task automatic test_start_while_busy;
    int ts, tb_, tn, td, extra;
    logic [15:0] e, e0;
    logic p, p0, bd;
    load_roi(8'h10);
    push_expect(8'h10, 16'd0, 1'b1);
    do_run(1'b1, ts, tb_, tn, td, e, p, p0, e0, bd);
    n_cmp++;
    if (td - tb_ !== RUN_LEN) begin n_bad++; $display("FAIL busy_start done latency: got %0d want %0d", td - tb_, RUN_LEN); end
    check_results("busy_start", e, p);
    // start raised in the DONE cycle must be ignored
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL done_start busy: got %b want 0", bus.busy); end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done || bus.busy) extra++;
      @(negedge clk);
    end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL done_start extra activity: got %0d want 0", extra); end
  endtask

  task automatic test_start_with_rst;
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_start busy: got %b want 0", bus.busy); end
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_start busy later: got %b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_clean_counter();
    test_wrap();
    test_fault(1, 8'h40, 16'd1);
    test_fault(2, 8'h05, 16'd18);
    test_reset_mid_run();
    test_start_while_busy();
    test_start_with_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
